// File: rtl/cam_pkg.sv
// Shared encodings for the camera capture path: pixel formats, downscale
// factors, capture FSM states and the RGB565 field positions.
package cam_pkg;

    localparam logic [1:0] MODE_RGB444 = 2'd0;
    localparam logic [1:0] MODE_RGB565 = 2'd1;
    localparam logic [1:0] MODE_GRAY   = 2'd2;

    localparam logic [1:0] SCALE_1 = 2'd0;
    localparam logic [1:0] SCALE_2 = 2'd1;
    localparam logic [1:0] SCALE_4 = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_ARMED   = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

endpackage

// File: rtl/pix_convert.sv
// Combinational RGB565 pixel formatter shared by the capture and VGA read paths.
// Reserved mode 3 falls through to RGB444.
module pix_convert
    import cam_pkg::*;
(
    input  logic [15:0] pixel,
    input  logic [1:0]  mode,
    output logic [15:0] data_out_next
);

    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic [7:0] red8;
    logic [7:0] green8;
    logic [7:0] blue8;
    logic [9:0] luma_sum;
    logic [7:0] luma;

    assign red   = pixel[R_MSB:R_LSB];
    assign green = pixel[G_MSB:G_LSB];
    assign blue  = pixel[B_MSB:B_LSB];

    // Replicate the top bits so full-scale channels map to 8'hFF.
    assign red8   = {red, red[4:2]};
    assign green8 = {green, green[5:4]};
    assign blue8  = {blue, blue[4:2]};

    assign luma_sum = {2'b00, red8} + {1'b0, green8, 1'b0} + {2'b00, blue8};
    assign luma     = 8'(luma_sum >> 2);

    always_comb begin
        data_out_next = '0;
        case (mode)
            MODE_RGB565: data_out_next = pixel;
            MODE_GRAY:   data_out_next = {8'h00, luma};
            default:     data_out_next = {4'h0, red[4:1], green[5:2], blue[4:1]};
        endcase
    end

endmodule

// File: rtl/cam_capture.sv
// OV-series camera byte-pair grabber: settle-frame skip, runtime format and
// downscale, raster-order frame-buffer writes, frame counting and line checks.
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 19,
    parameter int SKIP_FRAMES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_done,
    input  logic              capture_en,
    input  logic [1:0]        mode,
    input  logic [1:0]        scale,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data_in,
    output logic              we_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       data_out,
    output logic              frame_start,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              line_err
);

    // One spare bit so the counters can saturate past the active window.
    localparam int COL_W = $clog2(H_ACTIVE + 1) + 1;
    localparam int ROW_W = $clog2(V_ACTIVE + 1) + 1;

    localparam logic [COL_W-1:0] H_LIM   = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] V_LIM   = ROW_W'(V_ACTIVE);
    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    logic [1:0]        state;
    logic [3:0]        skip_cnt;
    logic              vsync_d;
    logic              href_d;
    logic              vs_rise;
    logic              href_fall;
    logic              phase;
    logic [7:0]        hi_byte;
    logic [1:0]        mode_q;
    logic [1:0]        scale_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] wr_addr;
    logic              keep;
    logic              in_window;
    logic              start_now;
    logic [15:0]       data_next;

    assign vs_rise   = vsync & ~vsync_d;
    assign href_fall = href_d & ~href;
    assign in_window = (col < H_LIM) && (row < V_LIM);
    assign start_now = cfg_done && vs_rise && capture_en &&
                       ((state == ST_ARMED) || (state == ST_CAPTURE));

    always_comb begin
        keep = 1'b1;
        case (scale_q)
            SCALE_2: keep = ~col[0] & ~row[0];
            SCALE_4: keep = (col[1:0] == 2'b00) && (row[1:0] == 2'b00);
            default: keep = 1'b1;
        endcase
    end

    pix_convert u_pix_convert (
        .pixel         ({hi_byte, data_in}),
        .mode          (mode_q),
        .data_out_next (data_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            skip_cnt    <= '0;
            phase       <= 1'b0;
            hi_byte     <= '0;
            mode_q      <= MODE_RGB444;
            scale_q     <= SCALE_1;
            col         <= '0;
            row         <= '0;
            wr_addr     <= '0;
            we_en       <= 1'b0;
            out_addr    <= '0;
            data_out    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            line_err    <= 1'b0;
        end else begin
            we_en       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            if (!cfg_done) begin
                state <= ST_IDLE;
                phase <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        skip_cnt <= 4'(SKIP_FRAMES);
                        state    <= ST_SKIP;
                    end
                    ST_SKIP: begin
                        if (skip_cnt == 4'd0) begin
                            state <= ST_ARMED;
                        end else if (vs_rise) begin
                            skip_cnt <= skip_cnt - 4'd1;
                            if (skip_cnt == 4'd1) begin
                                state <= ST_ARMED;
                            end
                        end
                    end
                    ST_ARMED: begin
                    end
                    default: begin
                        if (href) begin
                            if (!phase) begin
                                hi_byte <= data_in;
                                phase   <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (col != COL_MAX) begin
                                    col <= col + COL_W'(1);
                                end
                                if (keep && in_window) begin
                                    we_en    <= 1'b1;
                                    out_addr <= wr_addr;
                                    data_out <= data_next;
                                    wr_addr  <= wr_addr + ADDR_W'(1);
                                end
                            end
                        end else if (href_fall) begin
                            phase <= 1'b0;
                            col   <= '0;
                            if (row != ROW_MAX) begin
                                row <= row + ROW_W'(1);
                            end
                            if (col != H_LIM) begin
                                line_err <= 1'b1;
                            end
                        end
                        if (vs_rise) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + CNT_W'(1);
                            if (!capture_en) begin
                                state <= ST_ARMED;
                            end
                        end
                    end
                endcase

                // Placed after the byte path so a write landing on the frame
                // boundary keeps its old-frame address while counters restart.
                if (start_now) begin
                    state       <= ST_CAPTURE;
                    frame_start <= 1'b1;
                    mode_q      <= mode;
                    scale_q     <= (scale == 2'd3) ? SCALE_1 : scale;
                    wr_addr     <= '0;
                    col         <= '0;
                    row         <= '0;
                    phase       <= 1'b0;
                    line_err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on an 8x4 frame with one settle frame:
// format table, downscale, line error, stop/abort and async reset sequences.
module tb_cam_capture;
    import cam_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_done = 1'b0;
    logic          capture_en = 1'b0;
    logic [1:0]    mode = 2'd1;
    logic [1:0]    scale = 2'd0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          we_en;
    logic [AW-1:0] out_addr;
    logic [15:0]   data_out;
    logic          frame_start;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic          line_err;

    cam_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .ADDR_W      (AW),
        .SKIP_FRAMES (1),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_done    (cfg_done),
        .capture_en  (capture_en),
        .mode        (mode),
        .scale       (scale),
        .vsync       (vsync),
        .href        (href),
        .data_in     (data_in),
        .we_en       (we_en),
        .out_addr    (out_addr),
        .data_out    (data_out),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0]   mon_data[$];
    logic [AW-1:0] mon_addr[$];
    int            fs_cnt = 0;
    int            fd_cnt = 0;

    always @(negedge clk) begin
        if (we_en) begin
            mon_data.push_back(data_out);
            mon_addr.push_back(out_addr);
        end
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
    end

    int          pix_kind = 0;
    logic [15:0] pix_const = 16'hF81F;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] pix;
        logic [15:0] expect_data;
    } fmt_vec_t;

    fmt_vec_t fmt_tbl[7];

    function automatic logic [15:0] pix_at(input int r, input int c);
        if (pix_kind == 1) return 16'(c + (r << 4));
        return pix_const;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_vsync();
        @(negedge clk) vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int r, input int npix);
        logic [15:0] p;
        for (int c = 0; c < npix; c++) begin
            p = pix_at(r, c);
            @(negedge clk) href = 1'b1;
            data_in = p[15:8];
            @(negedge clk) data_in = p[7:0];
        end
        @(negedge clk) href = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    // One frame: boundary vsync then V lines, optionally one short by a pixel.
    task automatic applyStimulus(input int short_row);
        send_vsync();
        for (int r = 0; r < V; r++) send_line(r, (r == short_row) ? H - 1 : H);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int base, fs0, fd0;

        fmt_tbl[0] = '{2'd0, 16'hFFFF, 16'h0FFF};
        fmt_tbl[1] = '{2'd1, 16'hFFFF, 16'hFFFF};
        fmt_tbl[2] = '{2'd2, 16'hFFFF, 16'h00FF};
        fmt_tbl[3] = '{2'd2, 16'h07E0, 16'h007F};
        fmt_tbl[4] = '{2'd0, 16'h1234, 16'h014A};
        fmt_tbl[5] = '{2'd2, 16'hF81F, 16'h007F};
        fmt_tbl[6] = '{2'd3, 16'hF81F, 16'h0F0F};

        repeat (3) @(negedge clk);
        checkOutput("reset_we_en", {31'd0, we_en}, 32'd0);
        checkOutput("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        checkOutput("reset_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        rst = 1'b0;

        // Settle-frame skip, then two full captured frames
        cfg_done = 1'b1;
        capture_en = 1'b1;
        repeat (4) @(negedge clk);
        base = mon_data.size();
        applyStimulus(-1);
        checkOutput("skip_no_writes", 32'(mon_data.size() - base), 32'd0);
        fs0 = fs_cnt;
        applyStimulus(-1);
        checkOutput("f2_writes", 32'(mon_data.size() - base), 32'd32);
        checkOutput("f2_start", 32'(fs_cnt - fs0), 32'd1);
        for (int k = 0; k < 32 && base + k < mon_data.size(); k++) begin
            checkOutput($sformatf("f2_addr%0d", k), {27'd0, mon_addr[base + k]}, 32'(k));
            checkOutput($sformatf("f2_data%0d", k), {16'd0, mon_data[base + k]}, 32'h0000F81F);
        end
        fd0 = fd_cnt;
        base = mon_data.size();
        applyStimulus(-1);
        checkOutput("f2_done", 32'(fd_cnt - fd0), 32'd1);
        checkOutput("f2_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        checkOutput("f3_writes", 32'(mon_data.size() - base), 32'd32);
        if (mon_data.size() >= base + 32)
            checkOutput("f3_last_addr", {27'd0, mon_addr[base + 31]}, 32'd31);
        send_vsync();
        checkOutput("f3_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // Format table
        for (int i = 0; i < 7; i++) begin
            mode = fmt_tbl[i].mode;
            pix_const = fmt_tbl[i].pix;
            base = mon_data.size();
            applyStimulus(-1);
            checkOutput($sformatf("fmt%0d_writes", i), 32'(mon_data.size() - base), 32'd32);
            if (mon_data.size() >= base + 32) begin
                checkOutput($sformatf("fmt%0d_first", i), {16'd0, mon_data[base]}, {16'd0, fmt_tbl[i].expect_data});
                checkOutput($sformatf("fmt%0d_last", i), {16'd0, mon_data[base + 31]}, {16'd0, fmt_tbl[i].expect_data});
            end
        end

        // Downscale 1:2 and 1:4 with a position-coded pattern
        mode = 2'd1;
        pix_kind = 1;
        scale = 2'd1;
        base = mon_data.size();
        applyStimulus(-1);
        checkOutput("s2_writes", 32'(mon_data.size() - base), 32'd8);
        for (int k = 0; k < 8 && base + k < mon_data.size(); k++) begin
            checkOutput($sformatf("s2_addr%0d", k), {27'd0, mon_addr[base + k]}, 32'(k));
            checkOutput($sformatf("s2_data%0d", k), {16'd0, mon_data[base + k]},
                        32'(((k % 4) * 2) + (((k / 4) * 2) << 4)));
        end
        scale = 2'd2;
        base = mon_data.size();
        applyStimulus(-1);
        checkOutput("s4_writes", 32'(mon_data.size() - base), 32'd2);
        if (mon_data.size() >= base + 2)
            checkOutput("s4_data1", {16'd0, mon_data[base + 1]}, 32'h4);

        // Short line sets line_err, next frame_start clears it
        scale = 2'd0;
        base = mon_data.size();
        applyStimulus(1);
        checkOutput("lerr_set", {31'd0, line_err}, 32'd1);
        checkOutput("lerr_writes", 32'(mon_data.size() - base), 32'd31);
        if (mon_data.size() >= base + 31)
            checkOutput("lerr_last_addr", {27'd0, mon_addr[base + 30]}, 32'd30);
        send_vsync();
        checkOutput("lerr_clear", {31'd0, line_err}, 32'd0);

        // capture_en drops mid-frame: frame finishes, then nothing until re-enabled
        pix_kind = 0;
        pix_const = 16'hF81F;
        send_vsync();
        base = mon_data.size();
        send_line(0, H);
        send_line(1, H);
        capture_en = 1'b0;
        send_line(2, H);
        send_line(3, H);
        checkOutput("stop_writes", 32'(mon_data.size() - base), 32'd32);
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        base = mon_data.size();
        applyStimulus(-1);
        checkOutput("stop_done", 32'(fd_cnt - fd0), 32'd1);
        checkOutput("stop_no_start", 32'(fs_cnt - fs0), 32'd0);
        checkOutput("stop_no_writes", 32'(mon_data.size() - base), 32'd0);
        capture_en = 1'b1;
        fd0 = fd_cnt;
        applyStimulus(-1);
        checkOutput("resume_writes", 32'(mon_data.size() - base), 32'd32);
        checkOutput("resume_no_done", 32'(fd_cnt - fd0), 32'd0);

        // cfg_done falls mid-line on the byte that would complete a pixel
        send_vsync();
        base = mon_data.size();
        send_line(0, H);
        @(negedge clk) href = 1'b1;
        data_in = 8'hAB;
        @(negedge clk) data_in = 8'hCD;
        cfg_done = 1'b0;
        @(negedge clk);
        checkOutput("abort_we_en", {31'd0, we_en}, 32'd0);
        checkOutput("abort_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        href = 1'b0;
        fd0 = fd_cnt;
        send_vsync();
        checkOutput("abort_no_done", 32'(fd_cnt - fd0), 32'd0);
        checkOutput("abort_writes", 32'(mon_data.size() - base), 32'd8);

        // Async reset while a write strobe is high
        cfg_done = 1'b1;
        repeat (3) @(negedge clk);
        send_vsync();
        send_vsync();
        send_line(0, H);
        @(negedge clk) href = 1'b1;
        data_in = 8'hF8;
        @(negedge clk) data_in = 8'h1F;
        @(negedge clk);
        checkOutput("pre_rst_we_en", {31'd0, we_en}, 32'd1);
        checkOutput("pre_rst_addr", {27'd0, out_addr}, 32'd8);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_we_en", {31'd0, we_en}, 32'd0);
        checkOutput("rst_addr", {27'd0, out_addr}, 32'd0);
        checkOutput("rst_data", {16'd0, data_out}, 32'd0);
        checkOutput("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        checkOutput("rst_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        href = 1'b0;
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Parameterised successor to the fixed 640x480 RGB565-to-12-bit pixel grabber that sits behind SCCB configuration in the camera driver.
- Assembles OV-series byte pairs into pixels and writes them in raster order to the frame-buffer write port (we_en / out_addr / data_out).
- Adds four features over the fixed grabber: runtime pixel format (RGB444 / RGB565 / gray), 1/2/4 downscale, a post-config settle-frame skip, and frame counting with line-length error detection.

Parameters:
- H_ACTIVE, 640: active pixels per line (byte pairs per HREF).
- V_ACTIVE, 480: active lines per frame.
- ADDR_W, 19: out_addr width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.
- SKIP_FRAMES, 2: whole frames discarded after cfg_done rises; range 0..15.
- CNT_W, 16: frame_cnt width.

Ports:
- clk, input, 1: pixel clock (camera PCLK); all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- cfg_done, input, 1: SCCB configuration complete; level.
- capture_en, input, 1: keep capturing frames while high.
- mode, input, 2: 0=RGB444, 1=RGB565, 2=gray8, 3=reserved (treated as 0).
- scale, input, 2: 0=1:1, 1=1:2, 2=1:4, 3=reserved (treated as 0).
- vsync, input, 1: frame sync, active high; a rising edge marks a frame boundary.
- href, input, 1: line valid.
- data_in, input, 8: camera byte.
- we_en, output, 1: one-cycle write strobe.
- out_addr, output, ADDR_W: linear write address.
- data_out, output, 16: pixel, LSB-aligned, unused upper bits 0.
- frame_start, output, 1: one-cycle pulse when a captured frame begins.
- frame_done, output, 1: one-cycle pulse when a captured frame ends.
- frame_cnt, output, CNT_W: completed captured frames; wraps.
- line_err, output, 1: sticky per frame.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- vsync edge detect: a register holds vsync_d; vs_rise = vsync & ~vsync_d.
- FSM states:
  - IDLE: stay while cfg_done=0. When cfg_done=1, load skip_cnt=SKIP_FRAMES and go to SKIP.
  - SKIP: each vs_rise decrements skip_cnt. At 0 (or immediately if SKIP_FRAMES=0), go to ARMED.
  - ARMED: on vs_rise with capture_en=1, go to CAPTURE. In the same cycle: pulse frame_start; latch mode and scale into mode_q/scale_q; clear address, row/col counters, byte phase and line_err.
  - CAPTURE, on vs_rise: pulse frame_done and increment frame_cnt. If capture_en=1, also pulse frame_start in the same cycle, re-latch mode and scale, clear the counters and stay in CAPTURE. Otherwise go to ARMED.
  - cfg_done falling in any state: go to IDLE next cycle. we_en forced 0; no frame_done.
- Byte assembly, CAPTURE only:
  - A byte phase bit toggles on each href=1 cycle. Phase 0 byte is the high byte, phase 1 byte the low byte.
  - Pixel P = {hi, lo} as RGB565: R=P[15:11], G=P[10:5], B=P[4:0].
  - Phase and col reset when href falls. An odd trailing byte is discarded.
- Line accounting:
  - col counts completed pixels in the current line; row counts href falling edges.
  - Pixels with col >= H_ACTIVE or row >= V_ACTIVE are dropped (no we_en).
  - On href fall with col != H_ACTIVE, set line_err. It stays set until the next frame_start.
- Downscale, s = scale_q:
  - A pixel is kept iff col[s-1:0]==0 and row[s-1:0]==0. For s=0 every pixel is kept.
  - out_addr is a running counter incremented after each write, starting at 0 each frame. The last write address is (H_ACTIVE>>s)*(V_ACTIVE>>s)-1. There are no multipliers.
- Format conversion, mode_q:
  - RGB444: data_out[11:0] = {R[4:1], G[5:2], B[4:1]}.
  - RGB565: data_out = P.
  - gray8: first expand R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}. Then Y = (R8 + 2*G8 + B8) >> 2, using a 10-bit sum, and data_out[7:0] = Y.
- Write timing:
  - we_en, out_addr and data_out are registered and asserted in the cycle after the phase-1 byte is sampled (latency 1).
  - data_out and out_addr hold their values between strobes.
- Simultaneous events: if vs_rise coincides with a pending write, the write completes with the old frame's address. Counters are cleared after that write.
- Reset mid-frame: everything returns to IDLE and zero. A partial frame produces no frame_done.

Decomposition:
- Shared package cam_pkg holds:
  - mode and scale encodings (MODE_RGB444, MODE_RGB565, MODE_GRAY, SCALE_1/2/4);
  - FSM state encodings IDLE/SKIP/ARMED/CAPTURE;
  - the RGB565 field slice constants.
- One combinational sub-module, pix_convert: inputs P and mode_q; output 16-bit data_out_next. It is reusable by the VGA read path.

Test Plan (bench: H_ACTIVE=8, V_ACTIVE=4, SKIP_FRAMES=1):
- Skip: cfg_done=1, then 3 frames of pattern P=16'hF81F, mode=1, scale=0 -> frame 1 gives no we_en. Frames 2 and 3 each give 32 writes at addr 0..31 with data 16'hF81F, frame_start/frame_done pulses, and frame_cnt=1 after frame 2's end.
- Formats: P=16'hFFFF -> mode 0 gives 12'hFFF; mode 1 gives 16'hFFFF; mode 2 gives 8'hFF. P=16'h07E0, mode 2 -> Y=8'h7F.
- Downscale: scale=1, pixel value = col + (row<<4) -> 8 writes at addr 0..7 with data cols 0,2,4,6 of rows 0 and 2. Last addr 7.
- Line error: one line with 7 pixels -> line_err=1 within that frame. It clears at the next frame_start. That line gives 7 writes.
- Stop and abort: capture_en=0 mid-frame -> the frame completes with frame_done and no further we_en until capture_en=1 and the next vs_rise. cfg_done falling mid-line -> we_en=0 next cycle, state IDLE, no frame_done.
- Async reset asserted mid-line -> all outputs 0 immediately, with no clock edge required.
